// File: rtl/usb_phy_pkg.sv
// Shared definitions for the ULPI PHY connect/disconnect sequencer.
package usb_phy_pkg;

  typedef enum logic [2:0] {
    IDLE, WR, WR_WAIT, RD, RD_WAIT, NEXT, CONNECTED, FAULT
  } phy_state_e;

  // ULPI register addresses touched by the default tables
  localparam logic [7:0] OTG_CTL  = 8'h0A;
  localparam logic [7:0] FUNC_CTL = 8'h04;

  // {addr,data} pairs, entry 0 in the MSBs
  localparam logic [31:0] CONN_TABLE_DEF = {OTG_CTL, 8'h00, FUNC_CTL, 8'h45};
  localparam logic [31:0] DISC_TABLE_DEF = {OTG_CTL, 8'h00, FUNC_CTL, 8'h49};

endpackage

// File: rtl/usb_vbus_debounce.sv
// VBUS-valid debouncer: vb_ok rises after DEBOUNCE+1 consecutive valid
// samples and drops on the first invalid sample.
module usb_vbus_debounce #(
  parameter int DEBOUNCE = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] vbus_state,
  output logic       vb_ok
);
  localparam int CW = $clog2(DEBOUNCE + 1) + 1;

  logic [CW-1:0] cnt_q;

  // Count consecutive valid samples; any invalid sample restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vb_ok <= 1'b0;
    end else if (vbus_state != 2'b11) begin
      cnt_q <= '0;
      vb_ok <= 1'b0;
    end else if (cnt_q == CW'(DEBOUNCE)) begin
      vb_ok <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/usb_phy_seq.sv
// ULPI PHY sequencer: plays a connect or disconnect table of register
// writes, optionally verifying each by read-back, with per-entry retries.
module usb_phy_seq
  import usb_phy_pkg::*;
#(
  parameter int                    N_CONN     = 2,
  parameter int                    N_DISC     = 2,
  parameter logic [16*N_CONN-1:0]  CONN_TABLE = CONN_TABLE_DEF,
  parameter logic [16*N_DISC-1:0]  DISC_TABLE = DISC_TABLE_DEF,
  parameter int                    VERIFY     = 1,
  parameter int                    MAX_RETRY  = 3,
  parameter int                    TIMEOUT    = 255,
  parameter int                    DEBOUNCE   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usb_enable,
  input  logic [1:0] vbus_state,
  input  logic       reconnect,
  output logic       reg_en,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_din,
  input  logic       reg_rdy,
  input  logic [7:0] reg_dout,
  output logic       connected,
  output logic       busy,
  output logic       error
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  phy_state_e    state_q;
  logic [2:0]    idx_q;
  logic          disc_q;      // 1: playing the disconnect table
  logic [RW-1:0] retry_q;
  logic [TW-1:0] tmo_q;
  logic          error_q;
  logic [7:0]    addr_q, din_q;
  logic          vb_ok;

  usb_vbus_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .vbus_state (vbus_state),
    .vb_ok      (vb_ok)
  );

  // Table lookup: shift the wanted entry up to the MSBs
  function automatic logic [15:0] entry_f(input logic disc, input logic [2:0] i);
    logic [16*N_CONN-1:0] c;
    logic [16*N_DISC-1:0] d;
    c = CONN_TABLE << (16 * i);
    d = DISC_TABLE << (16 * i);
    return disc ? d[16*N_DISC-1 -: 16] : c[16*N_CONN-1 -: 16];
  endfunction

  logic [15:0] conn0_e, disc0_e, next_e;
  logic [2:0]  last_idx;
  logic        tmo_hit, attempt_fail;

  // Next-entry lookups and attempt-failure decode
  always_comb begin
    conn0_e      = entry_f(1'b0, 3'd0);
    disc0_e      = entry_f(1'b1, 3'd0);
    next_e       = entry_f(disc_q, idx_q + 3'd1);
    last_idx     = disc_q ? 3'(N_DISC - 1) : 3'(N_CONN - 1);
    tmo_hit      = (tmo_q == TW'(TIMEOUT - 1));
    attempt_fail = 1'b0;
    if (state_q == WR_WAIT)
      attempt_fail = !reg_rdy && tmo_hit;
    else if (state_q == RD_WAIT)
      attempt_fail = reg_rdy ? (reg_dout != din_q) : tmo_hit;
  end

  // Sequencer FSM; ready wins over a coincident timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      disc_q  <= 1'b0;
      retry_q <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_q <= '0;
          din_q  <= '0;
          if (usb_enable && vb_ok) begin
            disc_q  <= 1'b0;
            idx_q   <= '0;
            retry_q <= '0;
            {addr_q, din_q} <= conn0_e;
            state_q <= WR;
          end
        end
        WR, RD: begin
          tmo_q   <= '0;
          state_q <= (state_q == WR) ? WR_WAIT : RD_WAIT;
        end
        WR_WAIT, RD_WAIT: begin
          tmo_q <= tmo_q + TW'(1);
          if (attempt_fail) begin
            if (retry_q == RW'(MAX_RETRY)) begin
              error_q <= 1'b1;
              state_q <= FAULT;
            end else begin
              retry_q <= retry_q + RW'(1);
              state_q <= WR;
            end
          end else if (reg_rdy) begin
            state_q <= (state_q == WR_WAIT && VERIFY != 0) ? RD : NEXT;
          end
        end
        NEXT: begin
          retry_q <= '0;
          if (idx_q == last_idx) begin
            if (disc_q) begin
              addr_q  <= '0;
              din_q   <= '0;
              state_q <= IDLE;
            end else begin
              state_q <= CONNECTED;
            end
          end else begin
            idx_q   <= idx_q + 3'd1;
            {addr_q, din_q} <= next_e;
            state_q <= WR;
          end
        end
        CONNECTED: begin
          if (!usb_enable || !vb_ok || reconnect) begin
            disc_q  <= 1'b1;
            idx_q   <= '0;
            retry_q <= '0;
            {addr_q, din_q} <= disc0_e;
            state_q <= WR;
          end
        end
        FAULT: begin
          if (!usb_enable) begin
            error_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_en    = (state_q == WR) || (state_q == RD);
  assign reg_we    = (state_q == WR);
  assign reg_addr  = addr_q;
  assign reg_din   = din_q;
  assign connected = (state_q == CONNECTED);
  assign busy      = !((state_q == IDLE) || (state_q == CONNECTED) || (state_q == FAULT));
  assign error     = error_q;

endmodule

// File: doc/usb_phy_seq.md
USB_PHY_SEQ -- requirements
Module: usb_phy_seq

Interface
REQ-001 Parameter N_CONN, default 2, number of ULPI register writes in the connect sequence (1..8).
REQ-002 Parameter N_DISC, default 2, number of ULPI register writes in the disconnect sequence (1..8).
REQ-003 Parameter CONN_TABLE, default {8'h0A,8'h00, 8'h04,8'h45}, packed {addr,data} pairs, entry 0 in the most significant bits.
REQ-004 Parameter DISC_TABLE, default {8'h0A,8'h00, 8'h04,8'h49}, packed {addr,data} pairs, same order as CONN_TABLE.
REQ-005 Parameter VERIFY, default 1; when 1, each write is followed by a read-back of the same address.
REQ-006 Parameter MAX_RETRY, default 3, re-attempts per entry after a verify mismatch or timeout.
REQ-007 Parameter TIMEOUT, default 255, cycles allowed for reg_rdy per access.
REQ-008 Parameter DEBOUNCE, default 15, cycles vbus_state must be stable before it is acted on.
REQ-009 clk  in  1  single clock; all logic is on the rising edge.
REQ-010 rst_n  in  1  asynchronous, active-low reset.
REQ-011 usb_enable  in  1  level; request to be connected.
REQ-012 vbus_state  in  2  VBUS comparator state; 2'b11 = valid.
REQ-013 reconnect  in  1  single-cycle pulse; forces a disconnect then connect while connected.
REQ-014 reg_en  out  1  one-cycle register access strobe.
REQ-015 reg_we  out  1  write qualifier, valid with reg_en.
REQ-016 reg_addr  out  8  register address, stable from reg_en until reg_rdy.
REQ-017 reg_din  out  8  write data, stable from reg_en until reg_rdy.
REQ-018 reg_rdy  in  1  access-complete pulse.
REQ-019 reg_dout  in  8  read data, valid with reg_rdy.
REQ-020 connected  out  1  connect sequence finished, no error.
REQ-021 busy  out  1  a sequence is in progress.
REQ-022 error  out  1  sticky; a sequence entry exhausted its retries.

Function
REQ-023 States: IDLE, WR, WR_WAIT, RD, RD_WAIT, NEXT, CONNECTED, FAULT.
REQ-024 vb_ok is set only after vbus_state has been 2'b11 for DEBOUNCE+1 consecutive cycles; it clears the cycle after vbus_state leaves 2'b11.
REQ-025 IDLE -> WR with the connect table and index 0 when usb_enable & vb_ok.
REQ-026 CONNECTED -> WR with the disconnect table and index 0 on ~usb_enable, ~vb_ok, or reconnect.
REQ-027 WR: reg_en=reg_we=1 for exactly one cycle, then WR_WAIT.
REQ-028 WR_WAIT: on reg_rdy go to RD if VERIFY=1, else NEXT.
REQ-029 RD: reg_en=1, reg_we=0 for one cycle, then RD_WAIT.
REQ-030 RD_WAIT: on reg_rdy, go to NEXT if reg_dout equals the table data; otherwise count a retry and go to WR.
REQ-031 Timeout: when WR_WAIT or RD_WAIT has lasted TIMEOUT cycles, count a retry and go to WR.
REQ-032 When the retry count exceeds MAX_RETRY: set error and enter FAULT.
REQ-033 The retry counter clears on entry to each new index.
REQ-034 NEXT: increment the index, or at the last entry finish the sequence.
REQ-035 After a completed connect sequence: go to CONNECTED.
REQ-036 After a completed disconnect sequence: go to IDLE if reconnect triggered it, or to IDLE if the disconnect was caused by enable or VBUS.
REQ-037 After a reconnect-triggered disconnect, IDLE re-evaluates its entry condition next cycle, so the device reconnects automatically if usb_enable & vb_ok.
REQ-038 Exit from FAULT is only by ~usb_enable; this clears error and returns to IDLE.
REQ-039 A condition change mid-sequence does not abort the current sequence; it is acted on from CONNECTED or IDLE afterwards.
REQ-040 reconnect outside CONNECTED is ignored.
REQ-041 A reg_rdy outside WR_WAIT or RD_WAIT is ignored.
REQ-042 busy = state not in {IDLE, CONNECTED, FAULT}.
REQ-043 connected = (state == CONNECTED).
REQ-044 reg_addr and reg_din are registered and equal the current table entry; they are 0 in IDLE.

Reset
REQ-045 While rst_n is low: state=IDLE, all counters 0, vb_ok=0, error=0, and reg_en, reg_we, reg_addr, reg_din, connected, busy all 0, asynchronously.
REQ-046 Reset mid-access abandons the access with no further strobes; the sequence restarts from IDLE.

Structure
REQ-047 A shared package usb_phy_pkg holds the state encoding, the ULPI address constants (OTG_CTL 8'h0A, FUNC_CTL 8'h04), and the default table constants.
REQ-048 One sub-module, usb_vbus_debounce, implements REQ-024.

Verification
REQ-049 Scenario 1: defaults; vbus=11 for 20 cycles with usb_enable=1, PHY echoes writes -> writes (0A,00) then (04,45), each followed by a read; connected=1.
REQ-050 Scenario 2: from CONNECTED, drop vbus to 01 -> writes (0A,00) then (04,49); state IDLE; connected=0.
REQ-051 Scenario 3: first read-back of 04 returns 8'h41 -> entry is written again; on match the sequence completes; error=0.
REQ-052 Scenario 4: reg_rdy never asserts -> 4 attempts of entry 0, each TIMEOUT apart; error=1, state FAULT; usb_enable=0 clears it.
REQ-053 Scenario 5: reconnect pulse while connected -> disconnect sequence, then connect sequence, then connected=1 with no other stimulus.
REQ-054 Scenario 6: rst_n low during WR_WAIT -> all outputs 0 immediately; after release, the sequence restarts at entry 0.
